// File: rtl/bcd_seg_scan_if.sv
// Port bundle for bcd_seg_scan: BCD input strobe/data plus the scanned display drive.
interface bcd_seg_scan_if;
  logic       bcd_valid;
  logic [7:0] bcd;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (
    output bcd_valid, bcd, blank_lz,
    input  seg, an, err
  );

  modport slave (
    input  bcd_valid, bcd, blank_lz,
    output seg, an, err
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode 7-segment scanner with a frame-aligned
// double buffer, anti-ghosting gaps, leading-zero blanking and non-BCD flag.
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 4
) (
  input logic          clk,
  input logic          rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {D0, G0, D1, G1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    pend_reg, pend_next;
  logic          pend_f_reg, pend_f_next;
  logic [7:0]    shadow_reg, shadow_next;
  logic [6:0]    seg_reg, seg_next;
  logic [1:0]    an_reg, an_next;
  logic          err_reg, err_next;
  logic          frame_end;
  logic [1:0]    nib_bad;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // err tracks the value being loaded so it flips on the same edge as shadow.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nib
      assign nib_bad[gi] = (shadow_next[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg - CW'(1);
    frame_end  = 1'b0;
    case (state_reg)
      D0: if (cnt_reg == '0) begin
        if (GAP_CYCLES > 0) begin
          state_next = G0;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = D1;
          cnt_next   = DIV_LOAD;
        end
      end
      G0: if (cnt_reg == '0) begin
        state_next = D1;
        cnt_next   = DIV_LOAD;
      end
      D1: if (cnt_reg == '0) begin
        if (GAP_CYCLES > 0) begin
          state_next = G1;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = D0;
          cnt_next   = DIV_LOAD;
          frame_end  = 1'b1;
        end
      end
      G1: if (cnt_reg == '0) begin
        state_next = D0;
        cnt_next   = DIV_LOAD;
        frame_end  = 1'b1;
      end
      default: begin
        state_next = D0;
        cnt_next   = DIV_LOAD;
      end
    endcase
  end

  always_comb begin
    pend_next   = pend_reg;
    pend_f_next = pend_f_reg;
    shadow_next = shadow_reg;
    if (bus.bcd_valid) begin
      pend_next   = bus.bcd;
      pend_f_next = 1'b1;
    end
    // A strobe landing on the frame boundary bypasses pend so the newest value wins.
    if (frame_end) begin
      if (bus.bcd_valid)
        shadow_next = bus.bcd;
      else if (pend_f_reg)
        shadow_next = pend_reg;
      pend_f_next = 1'b0;
    end
    err_next = |nib_bad;
  end

  always_comb begin
    seg_next = 7'h7F;
    an_next  = 2'b11;
    case (state_reg)
      D0: begin
        an_next  = 2'b10;
        seg_next = decode(shadow_reg[3:0]);
      end
      D1: if (!(bus.blank_lz && shadow_reg[7:4] == 4'd0)) begin
        an_next  = 2'b01;
        seg_next = decode(shadow_reg[7:4]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= D0;
      cnt_reg    <= DIV_LOAD;
      pend_reg   <= 8'h00;
      pend_f_reg <= 1'b0;
      shadow_reg <= 8'h00;
      seg_reg    <= 7'h7F;
      an_reg     <= 2'b11;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pend_reg   <= pend_next;
      pend_f_reg <= pend_f_next;
      shadow_reg <= shadow_next;
      seg_reg    <= seg_next;
      an_reg     <= an_next;
      err_reg    <= err_next;
    end
  end

  assign bus.seg = seg_reg;
  assign bus.an  = an_reg;
  assign bus.err = err_reg;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with REFRESH_DIV=4, GAP_CYCLES=1 (10-cycle frame).
module tb_bcd_seg_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
    bit         seg_en;
    bit         err_en;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Edge k (counted from reset release) shows frame (k-1)/10, phase (k-1)%10;
  // err reflects frame f from its load edge 10f through 10f+9.
  task automatic expect_frame(input int f, input logic [7:0] v, input bit blz, input int lim);
    exp_t e;
    logic bad;
    bad = (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    $display("expect frame %0d: value %02h blank_lz %0d", f, v, blz);
    for (int p = 0; p < 10; p++) begin
      e = '{cyc: 10*f + 1 + p, seg: 7'h7F, an: 2'b11, err: 1'b0, seg_en: 1'b1, err_en: 1'b0};
      if (p < 4) begin
        e.an  = 2'b10;
        e.seg = dec(v[3:0]);
      end else if (p >= 5 && p < 9 && !(blz && v[7:4] == 4'd0)) begin
        e.an  = 2'b01;
        e.seg = dec(v[7:4]);
      end
      if (e.cyc <= lim) sb.push_back(e);
      e = '{cyc: 10*f + p, seg: 7'h7F, an: 2'b11, err: bad, seg_en: 1'b0, err_en: 1'b1};
      if (e.cyc > 0 && e.cyc <= lim) sb.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    check("an_not_both_low", {31'd0, bus.an != 2'b00}, 32'd1);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].seg_en) begin
          check("seg", {25'd0, bus.seg}, {25'd0, sb[i].seg});
          check("an", {30'd0, bus.an}, {30'd0, sb[i].an});
        end
        if (sb[i].err_en)
          check("err", {31'd0, bus.err}, {31'd0, sb[i].err});
        sb.delete(i);
      end
    end
  end

  task automatic at_edge(input int n);
    int guard;
    guard = 0;
    while (cyc != n - 1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("at_edge_timeout", 32'd1, 32'd0);
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.bcd_valid = 1'b1;
    bus.bcd       = v;
    $display("strobe bcd=%02h at edge %0d", v, cyc + 1);
    @(negedge clk);
    bus.bcd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_an", {30'd0, bus.an}, 32'd3);
    check("rst_err", {31'd0, bus.err}, 32'd0);
  endtask

  localparam int NOLIM = 1000000;

  initial begin
    rst_n         = 1'b0;
    bus.bcd_valid = 1'b0;
    bus.bcd       = 8'h00;
    bus.blank_lz  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    expect_frame(0, 8'h00, 1'b0, NOLIM);
    expect_frame(1, 8'h00, 1'b0, NOLIM);

    at_edge(14); strobe(8'h37);
    expect_frame(2, 8'h37, 1'b0, NOLIM);

    at_edge(24); bus.blank_lz = 1'b1; strobe(8'h05);
    expect_frame(3, 8'h05, 1'b1, NOLIM);
    at_edge(40); bus.blank_lz = 1'b0;
    expect_frame(4, 8'h05, 1'b0, NOLIM);

    at_edge(44); strobe(8'h1C);
    expect_frame(5, 8'h1C, 1'b0, NOLIM);
    expect_frame(6, 8'h1C, 1'b0, NOLIM);
    at_edge(62); strobe(8'h42);
    expect_frame(7, 8'h42, 1'b0, NOLIM);

    at_edge(72); strobe(8'h11);
    at_edge(76); strobe(8'h22);
    expect_frame(8, 8'h22, 1'b0, NOLIM);

    // Edge 90 is the last G1 cycle of frame 8: the strobe must show in frame 9.
    at_edge(90); strobe(8'h99);
    expect_frame(9, 8'h99, 1'b0, NOLIM);

    at_edge(95); strobe(8'h58);
    expect_frame(10, 8'h58, 1'b0, 106);
    at_edge(104); strobe(8'h63);
    at_edge(107); rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    expect_frame(0, 8'h00, 1'b0, NOLIM);
    expect_frame(1, 8'h00, 1'b0, NOLIM);
    expect_frame(2, 8'h00, 1'b0, NOLIM);
    at_edge(32);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Two-digit multiplexed seven-segment driver that consumes the 8-bit packed BCD produced by the code-converter stages (`gtobcd` and siblings) and scans it onto a common-anode display. It double-buffers the incoming value so a display frame never shows a torn mix of old and new digits. It also inserts anti-ghosting blank gaps between digits, optionally blanks a leading zero, and flags non-BCD nibbles.

## Interface
- `REFRESH_DIV`, 50000: cycles each digit is lit; must be ≥1.
- `GAP_CYCLES`, 4: cycles with both anodes off after each digit; 0 removes gap states.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `bcd_valid`  in  1  one-cycle strobe: `bcd` is valid this cycle.
- `bcd`  in  8  packed BCD; [7:4] tens, [3:0] units.
- `blank_lz`  in  1  1 = blank tens digit when it is 0.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}.
- `an`  out  2  active-low anodes; an[0] units, an[1] tens.
- `err`  out  1  displayed value contains a nibble > 9.

## Operation
- Registers:
  - `pend[7:0]` and `pend_f`: latest accepted input, not yet shown.
  - `shadow[7:0]`: the value being displayed.
  - State and a down-counter of width clog2(max(REFRESH_DIV, GAP_CYCLES)+1).
- Input acceptance:
  - No backpressure; every `bcd_valid` cycle is accepted.
  - `pend` ← `bcd` and `pend_f` ← 1; a later strobe overwrites an earlier one.
- FSM sequence: D0 (units lit) → G0 (gap) → D1 (tens lit) → G1 (gap) → D0.
  - Each Dx state lasts exactly REFRESH_DIV cycles; each Gx state lasts GAP_CYCLES cycles.
  - When GAP_CYCLES = 0, G0 and G1 are skipped: D0→D1→D0.
- Frame boundary: the last cycle of G1, or of D1 when GAP_CYCLES = 0.
  - On that edge, if `pend_f`=1: `shadow` ← `pend`, `pend_f` ← 0.
- Simultaneous `bcd_valid` on the boundary cycle:
  - `shadow` ← `bcd` directly (newest wins) and `pend_f` ← 0.
- Digit decode (active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Nibble A–F shows '-' (0x3F).
- Anode drive:
  - D0: `an`=2'b10, `seg`=decode(shadow[3:0]).
  - D1: `an`=2'b01, `seg`=decode(shadow[7:4]).
  - Gx: `an`=2'b11, `seg`=0x7F.
- Leading-zero blanking: in D1, if `blank_lz`=1 and shadow[7:4]=0, then `an`=2'b11 and `seg`=0x7F. The slot timing is unchanged.
- `err` = (shadow[7:4]>9) | (shadow[3:0]>9), registered. It updates only when `shadow` changes, so it is not sticky.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State=D0, counter loaded for D0, `shadow`=0x00, `pend`=0x00, `pend_f`=0.
  - `seg`=0x7F, `an`=2'b11, `err`=0.
  - Reset asserted mid-frame aborts the frame and discards any pending value.
- `seg`, `an` and `err` are registered. On each non-reset edge they take the values decoded from the state and `shadow` present before that edge, so outputs lag state by one cycle.
  - First edge after reset release: `an`=2'b10, `seg`=0x40.
- Update latency: a value accepted in frame N is first lit in the D0 slot of frame N+1.
  - Worst case ≈ 2·(REFRESH_DIV+GAP_CYCLES)+1 cycles from strobe to first lit digit.
- Frame period = 2·(REFRESH_DIV+GAP_CYCLES) cycles, constant regardless of input activity.
- `an` never has both bits 0 in any cycle.

## Test plan
Parameters for all scenarios: REFRESH_DIV=4, GAP_CYCLES=1 (frame = 10 cycles).
- Reset: hold `rst_n`=0 for 3 cycles, then release → during reset `seg`=0x7F, `an`=11, `err`=0; from the first edge after release the repeating pattern is 4×(an=10, seg=0x40), 1×(11, 0x7F), 4×(01, 0x40), 1×(11, 0x7F).
- Basic display: strobe `bcd`=0x37 mid-frame → the current frame still shows "00"; the next frame shows units seg=0x78 and tens seg=0x30; `err`=0.
- Leading-zero blank: `bcd`=0x05 with `blank_lz`=1 → units seg=0x12; the D1 slot has an=11, seg=0x7F. With `blank_lz`=0, the D1 slot has an=01, seg=0x40.
- Invalid BCD: `bcd`=0x1C → tens seg=0x79, units seg=0x3F; `err`=1 from the load edge until a valid value such as 0x42 is loaded, after which `err`=0.
- Overwrite and boundary collision:
  - Strobe 0x11 then 0x22 within one frame → only 0x22 is ever displayed.
  - A strobe of 0x99 on the G1 boundary cycle → 0x99 is shown in the very next D0 slot.
- Reset mid-operation: 0x58 displayed with 0x63 pending, then assert `rst_n`=0 during D1 → outputs go 0x7F/11; after release "00" is displayed and 0x63 never appears.
